dcache_write_stage: RTL and testbench

DCACHE_WRITE_STAGE -- requirements
Module: dcache_write_stage

---
 rtl/dcache_write_stage_pkg.sv | 34 +++
 rtl/dcache_store_merge.sv | 28 ++
 rtl/dcache_write_stage.sv | 212 +++++++++++++++++++++
 tb/tb_dcache_write_stage.sv | 503 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_write_stage_pkg.sv
// Shared configuration for the D-cache write stage: default geometry,
// address-field positions, the line payload type and the FSM state enum.
package dcache_write_stage_pkg;

  // Default cache geometry
  localparam int unsigned CFG_TAG_W  = 19;  // addr[31:13]
  localparam int unsigned CFG_IDX_W  = 9;   // addr[12:4]
  localparam int unsigned CFG_WAYS   = 4;   // one-hot way vector

  // Data path widths
  localparam int unsigned ADDR_W         = 32;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned LINE_WORDS     = 4;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_SEL_W     = 2;

  // Address field positions
  localparam int unsigned WORD_LSB = 2;   // word select   addr[3:2]
  localparam int unsigned IDX_LSB  = 4;   // set index     addr[12:4]
  localparam int unsigned TAG_LSB  = 13;  // tag           addr[31:13]
  localparam int unsigned OFFSET_W = 4;   // byte offset within a line

  // One cache line, word n holds bytes 4n..4n+3
  typedef logic [LINE_WORDS-1:0][WORD_W-1:0] line_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WB    = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/dcache_store_merge.sv
// Byte-merge of store data into one word of a cache line.
// Ports:
//   line          - captured line (hit data or refill data)
//   word_sel      - word of the line addressed by the store (addr[3:2])
//   store_data    - store word, byte i in bits [8i+7:8i]
//   store_mask    - byte enables, byte i replaced when store_mask[i]
//   merged_line_c - line with the selected word's enabled bytes replaced
module dcache_store_merge
  import dcache_write_stage_pkg::*;
(
  input  line_t                   line,
  input  logic [WORD_SEL_W-1:0]   word_sel,
  input  logic [WORD_W-1:0]       store_data,
  input  logic [BYTES_PER_WORD-1:0] store_mask,
  output line_t                   merged_line_c
);

  // Untouched words pass through; only enabled bytes of the selected word change
  always_comb begin
    merged_line_c = line;
    for (int b = 0; b < int'(BYTES_PER_WORD); b++) begin
      if (store_mask[b]) begin
        merged_line_c[word_sel][b*BYTE_W +: BYTE_W] = store_data[b*BYTE_W +: BYTE_W];
      end
    end
  end

endmodule

// File: rtl/dcache_write_stage.sv
// D-cache write stage: takes one request at a time from the upstream arbiter,
// writes back a dirty victim if the miss needs it, performs the data/dir array
// write (store merge or refill), then returns the load or store response.
// Ports:
//   clock, reset          - sole clock, asynchronous active-low reset
//   io_in_*               - request handshake, address, directory result, line, store info
//   io_wb_*               - dirty-victim writeback (valid/ready)
//   io_arrWrite_*         - one-cycle data/dir array write, no back-pressure
//   io_loadResp_*         - load response (valid/ready)
//   io_storeResp_*        - store completion (valid/ready)
module dcache_write_stage
  import dcache_write_stage_pkg::*;
#(
  parameter int unsigned TAG_W = CFG_TAG_W,
  parameter int unsigned IDX_W = CFG_IDX_W,
  parameter int unsigned WAYS  = CFG_WAYS
) (
  input  logic                      clock,
  input  logic                      reset,

  output logic                      io_in_ready,
  input  logic                      io_in_valid,
  input  logic [ADDR_W-1:0]         io_in_bits_addr,
  input  logic                      io_in_bits_dirInfo_hit,
  input  logic [WAYS-1:0]           io_in_bits_dirInfo_chosenWay,
  input  logic                      io_in_bits_dirInfo_isDirtyWay,
  input  logic [TAG_W-1:0]          io_in_bits_dirtyTag,
  input  logic [WORD_W-1:0]         io_in_bits_data_0,
  input  logic [WORD_W-1:0]         io_in_bits_data_1,
  input  logic [WORD_W-1:0]         io_in_bits_data_2,
  input  logic [WORD_W-1:0]         io_in_bits_data_3,
  input  logic                      io_in_bits_isStore,
  input  logic [WORD_W-1:0]         io_in_bits_storeData,
  input  logic [BYTES_PER_WORD-1:0] io_in_bits_storeMask,

  output logic                      io_wb_valid,
  input  logic                      io_wb_ready,
  output logic [ADDR_W-1:0]         io_wb_bits_addr,
  output logic [WORD_W-1:0]         io_wb_bits_data_0,
  output logic [WORD_W-1:0]         io_wb_bits_data_1,
  output logic [WORD_W-1:0]         io_wb_bits_data_2,
  output logic [WORD_W-1:0]         io_wb_bits_data_3,

  output logic                      io_arrWrite_valid,
  output logic [IDX_W-1:0]          io_arrWrite_bits_set,
  output logic [WAYS-1:0]           io_arrWrite_bits_way,
  output logic [TAG_W-1:0]          io_arrWrite_bits_tag,
  output logic                      io_arrWrite_bits_dirty,
  output logic [WORD_W-1:0]         io_arrWrite_bits_data_0,
  output logic [WORD_W-1:0]         io_arrWrite_bits_data_1,
  output logic [WORD_W-1:0]         io_arrWrite_bits_data_2,
  output logic [WORD_W-1:0]         io_arrWrite_bits_data_3,

  output logic                      io_loadResp_valid,
  input  logic                      io_loadResp_ready,
  output logic [WORD_W-1:0]         io_loadResp_bits_data,

  output logic                      io_storeResp_valid,
  input  logic                      io_storeResp_ready
);

  state_e state_q;
  state_e state_d;

  // Request register
  logic [ADDR_W-1:0]         req_addr;
  logic                      req_hit;
  logic [WAYS-1:0]           req_way;
  logic                      req_is_dirty_way;
  logic [TAG_W-1:0]          req_dirty_tag;
  line_t                     req_line;
  logic                      req_is_store;
  logic [WORD_W-1:0]         req_store_data;
  logic [BYTES_PER_WORD-1:0] req_store_mask;

  logic                      in_fire;
  logic [WORD_SEL_W-1:0]     req_word_sel;
  line_t                     merged_line;
  line_t                     arr_line;

  assign in_fire      = io_in_valid && (state_q == ST_IDLE);
  assign req_word_sel = req_addr[WORD_LSB +: WORD_SEL_W];

  // Request capture; only the accepting handshake loads it, so a request
  // offered while busy never disturbs the one in flight
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      req_addr         <= '0;
      req_hit          <= 1'b0;
      req_way          <= '0;
      req_is_dirty_way <= 1'b0;
      req_dirty_tag    <= '0;
      req_line         <= '0;
      req_is_store     <= 1'b0;
      req_store_data   <= '0;
      req_store_mask   <= '0;
    end else if (in_fire) begin
      req_addr         <= io_in_bits_addr;
      req_hit          <= io_in_bits_dirInfo_hit;
      req_way          <= io_in_bits_dirInfo_chosenWay;
      req_is_dirty_way <= io_in_bits_dirInfo_isDirtyWay;
      req_dirty_tag    <= io_in_bits_dirtyTag;
      req_line         <= {io_in_bits_data_3, io_in_bits_data_2,
                           io_in_bits_data_1, io_in_bits_data_0};
      req_is_store     <= io_in_bits_isStore;
      req_store_data   <= io_in_bits_storeData;
      req_store_mask   <= io_in_bits_storeMask;
    end
  end

  // FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (in_fire) begin
          if (!io_in_bits_dirInfo_hit && io_in_bits_dirInfo_isDirtyWay) begin
            state_d = ST_WB;
          end else if (io_in_bits_isStore || !io_in_bits_dirInfo_hit) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_WB: begin
        if (io_wb_ready) begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (req_is_store ? io_storeResp_ready : io_loadResp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM outputs: handshake valids decoded from the state register
  always_comb begin
    io_in_ready        = 1'b0;
    io_wb_valid        = 1'b0;
    io_arrWrite_valid  = 1'b0;
    io_loadResp_valid  = 1'b0;
    io_storeResp_valid = 1'b0;
    case (state_q)
      ST_IDLE:  io_in_ready       = 1'b1;
      ST_WB:    io_wb_valid       = 1'b1;
      ST_WRITE: io_arrWrite_valid = 1'b1;
      ST_RESP: begin
        io_loadResp_valid  = !req_is_store;
        io_storeResp_valid = req_is_store;
      end
      default: begin
        io_in_ready = 1'b0;
      end
    endcase
  end

  dcache_store_merge u_store_merge (
    .line          (req_line),
    .word_sel      (req_word_sel),
    .store_data    (req_store_data),
    .store_mask    (req_store_mask),
    .merged_line_c (merged_line)
  );

  // Loads refill the captured line as-is; stores write the merged line
  assign arr_line = req_is_store ? merged_line : req_line;

  // Payloads come straight from the request register, so they stay stable
  // for as long as the matching valid is held
  assign io_wb_bits_addr   = ADDR_W'({req_dirty_tag,
                                      req_addr[IDX_LSB +: IDX_W],
                                      OFFSET_W'(0)});
  assign io_wb_bits_data_0 = req_line[0];
  assign io_wb_bits_data_1 = req_line[1];
  assign io_wb_bits_data_2 = req_line[2];
  assign io_wb_bits_data_3 = req_line[3];

  assign io_arrWrite_bits_set    = req_addr[IDX_LSB +: IDX_W];
  assign io_arrWrite_bits_way    = req_way;
  assign io_arrWrite_bits_tag    = req_addr[TAG_LSB +: TAG_W];
  assign io_arrWrite_bits_dirty  = req_is_store;
  assign io_arrWrite_bits_data_0 = arr_line[0];
  assign io_arrWrite_bits_data_1 = arr_line[1];
  assign io_arrWrite_bits_data_2 = arr_line[2];
  assign io_arrWrite_bits_data_3 = arr_line[3];

  assign io_loadResp_bits_data = req_line[req_word_sel];

  // Directory flags only steer the accept decision; the captured copies and
  // the byte offset are kept in the request register but not consumed later
  logic unused_req_bits;
  assign unused_req_bits = ^{req_addr[WORD_LSB-1:0], req_hit, req_is_dirty_way};

endmodule

// File: tb/tb_dcache_write_stage.sv
// Self-checking bench for dcache_write_stage: directed scenarios plus a
// randomized back-to-back run, with expectations queued at stimulus time.
module tb_dcache_write_stage;

  logic         clock;
  logic         reset;
  logic         io_in_ready;
  logic         io_in_valid;
  logic [31:0]  io_in_bits_addr;
  logic         io_in_bits_dirInfo_hit;
  logic [3:0]   io_in_bits_dirInfo_chosenWay;
  logic         io_in_bits_dirInfo_isDirtyWay;
  logic [18:0]  io_in_bits_dirtyTag;
  logic [31:0]  io_in_bits_data_0, io_in_bits_data_1, io_in_bits_data_2, io_in_bits_data_3;
  logic         io_in_bits_isStore;
  logic [31:0]  io_in_bits_storeData;
  logic [3:0]   io_in_bits_storeMask;
  logic         io_wb_valid;
  logic         io_wb_ready;
  logic [31:0]  io_wb_bits_addr;
  logic [31:0]  io_wb_bits_data_0, io_wb_bits_data_1, io_wb_bits_data_2, io_wb_bits_data_3;
  logic         io_arrWrite_valid;
  logic [8:0]   io_arrWrite_bits_set;
  logic [3:0]   io_arrWrite_bits_way;
  logic [18:0]  io_arrWrite_bits_tag;
  logic         io_arrWrite_bits_dirty;
  logic [31:0]  io_arrWrite_bits_data_0, io_arrWrite_bits_data_1;
  logic [31:0]  io_arrWrite_bits_data_2, io_arrWrite_bits_data_3;
  logic         io_loadResp_valid;
  logic         io_loadResp_ready;
  logic [31:0]  io_loadResp_bits_data;
  logic         io_storeResp_valid;
  logic         io_storeResp_ready;

  dcache_write_stage dut (
    .clock                         (clock),
    .reset                         (reset),
    .io_in_ready                   (io_in_ready),
    .io_in_valid                   (io_in_valid),
    .io_in_bits_addr               (io_in_bits_addr),
    .io_in_bits_dirInfo_hit        (io_in_bits_dirInfo_hit),
    .io_in_bits_dirInfo_chosenWay  (io_in_bits_dirInfo_chosenWay),
    .io_in_bits_dirInfo_isDirtyWay (io_in_bits_dirInfo_isDirtyWay),
    .io_in_bits_dirtyTag           (io_in_bits_dirtyTag),
    .io_in_bits_data_0             (io_in_bits_data_0),
    .io_in_bits_data_1             (io_in_bits_data_1),
    .io_in_bits_data_2             (io_in_bits_data_2),
    .io_in_bits_data_3             (io_in_bits_data_3),
    .io_in_bits_isStore            (io_in_bits_isStore),
    .io_in_bits_storeData          (io_in_bits_storeData),
    .io_in_bits_storeMask          (io_in_bits_storeMask),
    .io_wb_valid                   (io_wb_valid),
    .io_wb_ready                   (io_wb_ready),
    .io_wb_bits_addr               (io_wb_bits_addr),
    .io_wb_bits_data_0             (io_wb_bits_data_0),
    .io_wb_bits_data_1             (io_wb_bits_data_1),
    .io_wb_bits_data_2             (io_wb_bits_data_2),
    .io_wb_bits_data_3             (io_wb_bits_data_3),
    .io_arrWrite_valid             (io_arrWrite_valid),
    .io_arrWrite_bits_set          (io_arrWrite_bits_set),
    .io_arrWrite_bits_way          (io_arrWrite_bits_way),
    .io_arrWrite_bits_tag          (io_arrWrite_bits_tag),
    .io_arrWrite_bits_dirty        (io_arrWrite_bits_dirty),
    .io_arrWrite_bits_data_0       (io_arrWrite_bits_data_0),
    .io_arrWrite_bits_data_1       (io_arrWrite_bits_data_1),
    .io_arrWrite_bits_data_2       (io_arrWrite_bits_data_2),
    .io_arrWrite_bits_data_3       (io_arrWrite_bits_data_3),
    .io_loadResp_valid             (io_loadResp_valid),
    .io_loadResp_ready             (io_loadResp_ready),
    .io_loadResp_bits_data         (io_loadResp_bits_data),
    .io_storeResp_valid            (io_storeResp_valid),
    .io_storeResp_ready            (io_storeResp_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0]  addr;
    logic [127:0] line;
  } wb_exp_t;

  typedef struct packed {
    logic [8:0]   set;
    logic [3:0]   way;
    logic [18:0]  tag;
    logic         dirty;
    logic [127:0] line;
  } arr_exp_t;

  typedef struct packed {
    logic        is_store;
    logic [31:0] data;
  } resp_exp_t;

  wb_exp_t   wb_q[$];
  arr_exp_t  arr_q[$];
  resp_exp_t resp_q[$];

  int passed;
  int total;

  logic [127:0] wb_line;
  logic [127:0] arr_line;
  assign wb_line  = {io_wb_bits_data_3, io_wb_bits_data_2, io_wb_bits_data_1, io_wb_bits_data_0};
  assign arr_line = {io_arrWrite_bits_data_3, io_arrWrite_bits_data_2,
                     io_arrWrite_bits_data_1, io_arrWrite_bits_data_0};

  // Reference byte merge: mask expanded to a bit mask, then AND/OR blend
  function automatic logic [127:0] merge_model(input logic [127:0] line, input logic [1:0] w,
                                               input logic [31:0] sd, input logic [3:0] mask);
    logic [31:0]  bm;
    logic [127:0] r;
    int           base;
    bm   = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
    base = int'(w) * 32;
    r    = line;
    r[base +: 32] = (line[base +: 32] & ~bm) | (sd & bm);
    return r;
  endfunction

  function automatic logic [31:0] word_of(input logic [127:0] line, input logic [1:0] w);
    return line[int'(w) * 32 +: 32];
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_req(input logic [31:0] addr, input logic hit, input logic [3:0] way,
                           input logic dway, input logic [18:0] dtag, input logic [127:0] line,
                           input logic st, input logic [31:0] sd, input logic [3:0] mask);
    io_in_valid                   = 1'b1;
    io_in_bits_addr               = addr;
    io_in_bits_dirInfo_hit        = hit;
    io_in_bits_dirInfo_chosenWay  = way;
    io_in_bits_dirInfo_isDirtyWay = dway;
    io_in_bits_dirtyTag           = dtag;
    io_in_bits_data_0             = line[31:0];
    io_in_bits_data_1             = line[63:32];
    io_in_bits_data_2             = line[95:64];
    io_in_bits_data_3             = line[127:96];
    io_in_bits_isStore            = st;
    io_in_bits_storeData          = sd;
    io_in_bits_storeMask          = mask;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    total++;
    if ({io_in_ready, io_wb_valid, io_arrWrite_valid, io_loadResp_valid, io_storeResp_valid} !== 5'b10000)
      $display("FAIL reset_async_outputs: got %b want 10000",
               {io_in_ready, io_wb_valid, io_arrWrite_valid, io_loadResp_valid, io_storeResp_valid});
    else passed++;
    step();
    step();
    total++;
    if ({io_in_ready, io_wb_valid, io_arrWrite_valid, io_loadResp_valid, io_storeResp_valid} !== 5'b10000)
      $display("FAIL reset_held_outputs: got %b want 10000",
               {io_in_ready, io_wb_valid, io_arrWrite_valid, io_loadResp_valid, io_storeResp_valid});
    else passed++;
    total++;
    if ({io_arrWrite_bits_set, io_arrWrite_bits_tag, arr_line, io_wb_bits_addr, io_loadResp_bits_data} !== '0)
      $display("FAIL reset_req_cleared: set=%h tag=%h line=%h wbaddr=%h ld=%h want all 0",
               io_arrWrite_bits_set, io_arrWrite_bits_tag, arr_line, io_wb_bits_addr, io_loadResp_bits_data);
    else passed++;
    reset = 1'b1;
    step();
  endtask

  task automatic test_load_hit();
    resp_exp_t r;
    drive_req(32'h0000_1238, 1'b1, 4'b0010, 1'b0, 19'h0,
              {32'h3333_3333, 32'hCAFE_BABE, 32'h1111_1111, 32'h0000_0000}, 1'b0, 32'h0, 4'h0);
    resp_q.push_back('{1'b0, 32'hCAFE_BABE});
    io_loadResp_ready = 1'b1;
    step();
    io_in_valid = 1'b0;
    r = resp_q.pop_front();
    total++;
    if ({io_loadResp_valid, io_storeResp_valid, io_arrWrite_valid, io_wb_valid, io_in_ready} !== 5'b10000)
      $display("FAIL load_hit_valids: got %b want 10000",
               {io_loadResp_valid, io_storeResp_valid, io_arrWrite_valid, io_wb_valid, io_in_ready});
    else passed++;
    total++;
    if (io_loadResp_bits_data !== r.data)
      $display("FAIL load_hit_data: got %h want %h", io_loadResp_bits_data, r.data);
    else passed++;
    step();
    total++;
    if ({io_in_ready, io_loadResp_valid, io_arrWrite_valid} !== 3'b100)
      $display("FAIL load_hit_done: got %b want 100", {io_in_ready, io_loadResp_valid, io_arrWrite_valid});
    else passed++;
  endtask

  task automatic test_store_hit();
    logic [127:0] line;
    arr_exp_t     a;
    resp_exp_t    r;
    line = {32'h0303_0303, 32'h0202_0202, 32'hAABB_CCDD, 32'h0101_0101};
    drive_req(32'h0000_2004, 1'b1, 4'b0100, 1'b0, 19'h0, line, 1'b1, 32'h1122_3344, 4'b0101);
    arr_q.push_back('{9'h000, 4'b0100, 19'h1, 1'b1, merge_model(line, 2'd1, 32'h1122_3344, 4'b0101)});
    resp_q.push_back('{1'b1, 32'h0});
    io_storeResp_ready = 1'b1;
    step();
    io_in_valid = 1'b0;
    a = arr_q.pop_front();
    total++;
    if ({io_arrWrite_valid, io_storeResp_valid, io_wb_valid} !== 3'b100)
      $display("FAIL store_hit_write_cycle: got %b want 100", {io_arrWrite_valid, io_storeResp_valid, io_wb_valid});
    else passed++;
    total++;
    if (io_arrWrite_bits_data_1 !== 32'hAA22_CC44)
      $display("FAIL store_hit_word1: got %h want aa22cc44", io_arrWrite_bits_data_1);
    else passed++;
    total++;
    if ({io_arrWrite_bits_set, io_arrWrite_bits_way, io_arrWrite_bits_tag, io_arrWrite_bits_dirty, arr_line} !== a)
      $display("FAIL store_hit_arr: got set=%h way=%b tag=%h dirty=%b line=%h want set=%h way=%b tag=%h dirty=%b line=%h",
               io_arrWrite_bits_set, io_arrWrite_bits_way, io_arrWrite_bits_tag, io_arrWrite_bits_dirty, arr_line,
               a.set, a.way, a.tag, a.dirty, a.line);
    else passed++;
    step();
    r = resp_q.pop_front();
    total++;
    if ({io_arrWrite_valid, io_storeResp_valid, io_loadResp_valid} !== {1'b0, r.is_store, !r.is_store})
      $display("FAIL store_hit_resp_cycle: got %b want 010", {io_arrWrite_valid, io_storeResp_valid, io_loadResp_valid});
    else passed++;
    step();
    total++;
    if ({io_in_ready, io_storeResp_valid} !== 2'b10)
      $display("FAIL store_hit_done: got %b want 10", {io_in_ready, io_storeResp_valid});
    else passed++;
  endtask

  task automatic test_dirty_miss();
    logic [127:0] line;
    wb_exp_t      w;
    arr_exp_t     a;
    resp_exp_t    r;
    line = {32'hD3D3_D3D3, 32'hD2D2_D2D2, 32'hD1D1_D1D1, 32'h600D_F00D};
    drive_req(32'h8000_4010, 1'b0, 4'b1000, 1'b1, 19'h12345, line, 1'b0, 32'h0, 4'h0);
    wb_q.push_back('{32'h2468_A010, line});
    arr_q.push_back('{9'h001, 4'b1000, 19'h40002, 1'b0, line});
    resp_q.push_back('{1'b0, 32'h600D_F00D});
    io_wb_ready = 1'b0;
    io_loadResp_ready = 1'b1;
    step();
    io_in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({io_wb_valid, io_arrWrite_valid, io_in_ready} !== 3'b100 || io_wb_bits_addr !== wb_q[0].addr
          || wb_line !== wb_q[0].line)
        $display("FAIL dirty_miss_wb_hold[%0d]: got v=%b arr=%b rdy=%b addr=%h line=%h want v=1 arr=0 rdy=0 addr=%h line=%h",
                 i, io_wb_valid, io_arrWrite_valid, io_in_ready, io_wb_bits_addr, wb_line, wb_q[0].addr, wb_q[0].line);
      else passed++;
      if (i == 3) io_wb_ready = 1'b1;
      step();
    end
    w = wb_q.pop_front();
    io_wb_ready = 1'b0;
    a = arr_q.pop_front();
    total++;
    if ({io_wb_valid, io_arrWrite_valid} !== 2'b01)
      $display("FAIL dirty_miss_write_cycle: got wb=%b arr=%b want wb=0 arr=1 (wb addr was %h)",
               io_wb_valid, io_arrWrite_valid, w.addr);
    else passed++;
    total++;
    if ({io_arrWrite_bits_set, io_arrWrite_bits_way, io_arrWrite_bits_tag, io_arrWrite_bits_dirty, arr_line} !== a)
      $display("FAIL dirty_miss_arr: got set=%h tag=%h dirty=%b line=%h want set=%h tag=%h dirty=%b line=%h",
               io_arrWrite_bits_set, io_arrWrite_bits_tag, io_arrWrite_bits_dirty, arr_line,
               a.set, a.tag, a.dirty, a.line);
    else passed++;
    step();
    r = resp_q.pop_front();
    total++;
    if ({io_loadResp_valid, io_storeResp_valid, io_arrWrite_valid} !== 3'b100 || io_loadResp_bits_data !== r.data)
      $display("FAIL dirty_miss_resp: got v=%b%b%b data=%h want 100 data=%h",
               io_loadResp_valid, io_storeResp_valid, io_arrWrite_valid, io_loadResp_bits_data, r.data);
    else passed++;
    step();
  endtask

  task automatic test_resp_backpressure();
    logic [127:0] line_a;
    logic [127:0] line_b;
    resp_exp_t    r;
    arr_exp_t     a;
    line_a = {32'hA3A3_A3A3, 32'hA2A2_A2A2, 32'hA1A1_A1A1, 32'hA0A0_A0A0};
    line_b = {32'hB3B3_B3B3, 32'hB2B2_B2B2, 32'hB1B1_B1B1, 32'hB0B0_B0B0};
    io_loadResp_ready  = 1'b0;
    io_storeResp_ready = 1'b1;
    drive_req(32'h0000_0104, 1'b1, 4'b0001, 1'b0, 19'h0, line_a, 1'b0, 32'h0, 4'h0);
    resp_q.push_back('{1'b0, 32'hA1A1_A1A1});
    step();
    drive_req(32'h0000_0308, 1'b1, 4'b0010, 1'b0, 19'h0, line_b, 1'b1, 32'hFFEE_DDCC, 4'b1111);
    arr_q.push_back('{9'h030, 4'b0010, 19'h0, 1'b1, merge_model(line_b, 2'd2, 32'hFFEE_DDCC, 4'b1111)});
    resp_q.push_back('{1'b1, 32'h0});
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({io_in_ready, io_loadResp_valid, io_arrWrite_valid} !== 3'b010 || io_loadResp_bits_data !== resp_q[0].data)
        $display("FAIL backpressure_hold[%0d]: got rdy=%b v=%b arr=%b data=%h want 010 data=%h",
                 i, io_in_ready, io_loadResp_valid, io_arrWrite_valid, io_loadResp_bits_data, resp_q[0].data);
      else passed++;
      if (i == 4) io_loadResp_ready = 1'b1;
      step();
    end
    r = resp_q.pop_front();
    total++;
    if ({io_in_ready, io_loadResp_valid} !== 2'b10)
      $display("FAIL backpressure_release: got %b want 10 (last data %h)", {io_in_ready, io_loadResp_valid}, r.data);
    else passed++;
    step();
    io_in_valid = 1'b0;
    a = arr_q.pop_front();
    total++;
    if (io_arrWrite_valid !== 1'b1 || arr_line !== a.line || io_arrWrite_bits_set !== a.set)
      $display("FAIL backpressure_second_req: got v=%b set=%h line=%h want v=1 set=%h line=%h",
               io_arrWrite_valid, io_arrWrite_bits_set, arr_line, a.set, a.line);
    else passed++;
    step();
    r = resp_q.pop_front();
    total++;
    if ({io_storeResp_valid, io_loadResp_valid} !== {r.is_store, !r.is_store})
      $display("FAIL backpressure_second_resp: got %b want 10", {io_storeResp_valid, io_loadResp_valid});
    else passed++;
    step();
  endtask

  task automatic test_mask_zero();
    logic [127:0] line;
    arr_exp_t     a;
    line = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    drive_req(32'h0000_0A0C, 1'b1, 4'b0001, 1'b0, 19'h0, line, 1'b1, 32'hDEAD_BEEF, 4'b0000);
    arr_q.push_back('{9'h0A0, 4'b0001, 19'h0, 1'b1, line});
    io_storeResp_ready = 1'b1;
    step();
    io_in_valid = 1'b0;
    a = arr_q.pop_front();
    total++;
    if (io_arrWrite_valid !== 1'b1 || io_arrWrite_bits_dirty !== a.dirty || arr_line !== a.line
        || io_arrWrite_bits_set !== a.set)
      $display("FAIL mask_zero_write: got v=%b dirty=%b set=%h line=%h want v=1 dirty=%b set=%h line=%h",
               io_arrWrite_valid, io_arrWrite_bits_dirty, io_arrWrite_bits_set, arr_line, a.dirty, a.set, a.line);
    else passed++;
    step();
    step();
  endtask

  task automatic test_reset_in_wb();
    drive_req(32'h8000_4010, 1'b0, 4'b1000, 1'b1, 19'h12345,
              {32'h1, 32'h2, 32'h3, 32'h4}, 1'b1, 32'h5, 4'hF);
    io_wb_ready = 1'b0;
    step();
    io_in_valid = 1'b0;
    total++;
    if (io_wb_valid !== 1'b1)
      $display("FAIL reset_wb_entered: got %b want 1", io_wb_valid);
    else passed++;
    #2;
    reset = 1'b0;
    #1;
    total++;
    if ({io_wb_valid, io_arrWrite_valid, io_in_ready} !== 3'b001)
      $display("FAIL reset_wb_drop: got %b want 001", {io_wb_valid, io_arrWrite_valid, io_in_ready});
    else passed++;
    step();
    reset = 1'b1;
    io_wb_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      total++;
      if ({io_wb_valid, io_arrWrite_valid, io_storeResp_valid, io_in_ready} !== 4'b0001)
        $display("FAIL reset_wb_abandoned[%0d]: got %b want 0001",
                 i, {io_wb_valid, io_arrWrite_valid, io_storeResp_valid, io_in_ready});
      else passed++;
      step();
    end
    io_wb_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    io_wb_ready        = 1'b1;
    io_loadResp_ready  = 1'b1;
    io_storeResp_ready = 1'b1;
    for (int t = 0; t < 12; t++) begin
      logic [31:0]  addr;
      logic         hit, dway, st;
      logic [3:0]   way, mask;
      logic [18:0]  dtag;
      logic [31:0]  sd;
      logic [127:0] line;
      int           exp_lat;
      int           lat;
      bit           done;
      addr = $urandom;
      hit  = 1'($urandom_range(0, 1));
      dway = 1'($urandom_range(0, 1));
      st   = 1'($urandom_range(0, 1));
      way  = 4'(1 << $urandom_range(0, 3));
      mask = 4'($urandom_range(0, 15));
      dtag = 19'($urandom);
      sd   = $urandom;
      line = {$urandom, $urandom, $urandom, $urandom};
      drive_req(addr, hit, way, dway, dtag, line, st, sd, mask);
      if (!hit && dway) wb_q.push_back('{{dtag, addr[12:4], 4'h0}, line});
      if (st || !hit)
        arr_q.push_back('{addr[12:4], way, addr[31:13], st,
                          st ? merge_model(line, addr[3:2], sd, mask) : line});
      resp_q.push_back('{st, word_of(line, addr[3:2])});
      exp_lat = (!hit && dway) ? 3 : ((st || !hit) ? 2 : 1);
      step();
      io_in_valid = 1'b0;
      lat  = 0;
      done = 1'b0;
      for (int c = 0; c < 10 && !done; c++) begin
        lat++;
        if (io_wb_valid) begin
          total++;
          if (wb_q.size() == 0) begin
            $display("FAIL b2b_wb_unexpected[%0d]: got wb_valid=1 want 0", t);
          end else begin
            wb_exp_t w;
            w = wb_q.pop_front();
            if (io_wb_bits_addr !== w.addr || wb_line !== w.line)
              $display("FAIL b2b_wb[%0d]: got addr=%h line=%h want addr=%h line=%h",
                       t, io_wb_bits_addr, wb_line, w.addr, w.line);
            else passed++;
          end
        end
        if (io_arrWrite_valid) begin
          total++;
          if (arr_q.size() == 0) begin
            $display("FAIL b2b_arr_unexpected[%0d]: got arrWrite_valid=1 want 0", t);
          end else begin
            arr_exp_t a;
            a = arr_q.pop_front();
            if ({io_arrWrite_bits_set, io_arrWrite_bits_way, io_arrWrite_bits_tag,
                 io_arrWrite_bits_dirty, arr_line} !== a)
              $display("FAIL b2b_arr[%0d]: got set=%h way=%b tag=%h dirty=%b line=%h want set=%h way=%b tag=%h dirty=%b line=%h",
                       t, io_arrWrite_bits_set, io_arrWrite_bits_way, io_arrWrite_bits_tag,
                       io_arrWrite_bits_dirty, arr_line, a.set, a.way, a.tag, a.dirty, a.line);
            else passed++;
          end
        end
        if (io_loadResp_valid || io_storeResp_valid) begin
          resp_exp_t r;
          r = resp_q.pop_front();
          done = 1'b1;
          total++;
          if ({io_loadResp_valid, io_storeResp_valid} !== {!r.is_store, r.is_store}
              || (!r.is_store && io_loadResp_bits_data !== r.data))
            $display("FAIL b2b_resp[%0d]: got ld=%b st=%b data=%h want ld=%b st=%b data=%h",
                     t, io_loadResp_valid, io_storeResp_valid, io_loadResp_bits_data,
                     !r.is_store, r.is_store, r.data);
          else passed++;
          total++;
          if (lat !== exp_lat)
            $display("FAIL b2b_latency[%0d]: got %0d want %0d", t, lat, exp_lat);
          else passed++;
        end
        step();
      end
      if (!done) begin
        total++;
        $display("FAIL b2b_timeout[%0d]: got no response within 10 cycles want one", t);
        resp_q.delete();
      end
      total++;
      if (wb_q.size() != 0 || arr_q.size() != 0)
        $display("FAIL b2b_missing[%0d]: got pending wb=%0d arr=%0d want 0 0", t, wb_q.size(), arr_q.size());
      else passed++;
      wb_q.delete();
      arr_q.delete();
    end
  endtask

  initial begin
    passed             = 0;
    total              = 0;
    reset              = 1'b0;
    io_in_valid        = 1'b0;
    drive_req(32'h0, 1'b0, 4'h0, 1'b0, 19'h0, 128'h0, 1'b0, 32'h0, 4'h0);
    io_in_valid        = 1'b0;
    io_wb_ready        = 1'b0;
    io_loadResp_ready  = 1'b0;
    io_storeResp_ready = 1'b0;
    test_reset();
    test_load_hit();
    test_store_hit();
    test_dirty_miss();
    test_resp_backpressure();
    test_mask_zero();
    test_reset_in_wb();
    wb_q.delete();
    arr_q.delete();
    resp_q.delete();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
